// File: rtl/write_full_ctrl.sv
// rtl/write_full_ctrl.sv - write-side full/almost-full/level controller for an async FIFO
// Optional sticky overflow flag enabled by defining WRITE_OVERFLOW_FLAG_EN.
module write_full_ctrl #(
    parameter int address            = 3,
    parameter int almost_full_margin = 2
) (
    input  logic               write_clk,
    input  logic               write_rst,
    input  logic               write_inc,
    input  logic [address:0]   sync_read_ptr,
    output logic [address:0]   write_ptr,
    output logic [address-1:0] write_addr,
    output logic               write_full,
    output logic               write_almost_full,
    output logic [address:0]   write_level,
    output logic               write_overflow
);

    localparam int depth = 1 << address;
    localparam logic [address:0] af_threshold = (address + 1)'(depth - almost_full_margin);

    logic [address:0] write_bin;
    logic [address:0] bin_next;
    logic [address:0] gray_next;
    logic [address:0] read_bin;
    logic [address:0] level_next;
    logic [address:0] full_gray;
    logic             write_accept;
    logic             full_next;
    logic             almost_full_next;

    assign write_accept = write_inc & ~write_full;
    assign bin_next     = write_bin + {{address{1'b0}}, write_accept};
    assign gray_next    = (bin_next >> 1) ^ bin_next;
    assign write_addr   = write_bin[address-1:0];

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        read_bin = '0;
        for (int i = 0; i <= address; i++) begin
            read_bin[i] = ^(sync_read_ptr >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_gray        = {~sync_read_ptr[address:address-1], sync_read_ptr[address-2:0]};
    assign full_next        = (gray_next == full_gray);
    assign level_next       = bin_next - read_bin;
    assign almost_full_next = (level_next >= af_threshold) | full_next;

    always_ff @(posedge write_clk) begin
        if (write_rst) begin
            write_bin         <= '0;
            write_ptr         <= '0;
            write_level       <= '0;
            write_full        <= 1'b0;
            write_almost_full <= 1'b0;
        end else begin
            write_bin         <= bin_next;
            write_ptr         <= gray_next;
            write_level       <= level_next;
            write_full        <= full_next;
            write_almost_full <= almost_full_next;
        end
    end

`ifdef WRITE_OVERFLOW_FLAG_EN
    always_ff @(posedge write_clk) begin
        if (write_rst) begin
            write_overflow <= 1'b0;
        end else if (write_inc && write_full) begin
            write_overflow <= 1'b1;
        end
    end
`else
    assign write_overflow = 1'b0;
`endif

endmodule
